eight_sign_mul: RTL and testbench

EIGHT_SIGN_MUL -- requirements
Module: eight_sign

---
 rtl/eight_sign_mul.sv | 67 ++++++
 tb/tb_eight_sign_mul.sv | 136 +++++++++++++
 2 files changed

// File: rtl/eight_sign_mul.sv
// Sign-magnitude 8x8 multiplier, two register stages.
// Ports: a/b magnitudes, asign/bsign signs, clk, rst_n (sync, low); m/sign product.
module eight_sign_mul (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        clk,
  input  logic        asign,
  input  logic        bsign,
  output logic [15:0] m,
  output logic        sign,
  input  logic        rst_n
);

  logic [7:0]  a_r;
  logic [7:0]  b_r;
  logic        as_r;
  logic        bs_r;
  logic [15:0] acc [8];
  logic        sign_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r  <= '0;
      b_r  <= '0;
      as_r <= 1'b0;
      bs_r <= 1'b0;
    end else begin
      a_r  <= a;
      b_r  <= b;
      as_r <= asign;
      bs_r <= bsign;
    end
  end

  assign acc[0] = {8'b0, a_r & {8{b_r[0]}}};

  // Each row folds one shifted partial product into the running sum
  // with a ripple chain; bit 0 has no carry-in, so it is a half adder.
  for (genvar i = 1; i < 8; i++) begin : g_row
    logic [15:0] pp;
    logic [15:0] c;
    assign pp   = {8'b0, a_r & {8{b_r[i]}}} << i;
    assign c[0] = 1'b0;
    for (genvar j = 0; j < 16; j++) begin : g_bit
      assign acc[i][j] = acc[i-1][j] ^ pp[j] ^ c[j];
      if (j < 15) begin : g_cy
        assign c[j+1] = (acc[i-1][j] & pp[j])
                      | (acc[i-1][j] & c[j])
                      | (pp[j] & c[j]);
      end
    end
  end

  // A zero product is always reported positive.
  assign sign_next = (as_r ^ bs_r) & (|acc[7]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m    <= '0;
      sign <= 1'b0;
    end else begin
      m    <= acc[7];
      sign <= sign_next;
    end
  end

endmodule

// File: tb/tb_eight_sign_mul.sv
// Scoreboard bench for eight_sign_mul.
// Driver queues expected products; monitor checks one per clock edge.
module tb_eight_sign_mul;

  logic [7:0]  a;
  logic [7:0]  b;
  logic        clk;
  logic        asign;
  logic        bsign;
  logic [15:0] m;
  logic        sign;
  logic        rst_n;

  logic [16:0] q[$];
  int          compared;
  int          mismatched;
  bit          done;

  eight_sign_mul dut (
    .a     (a),
    .b     (b),
    .clk   (clk),
    .asign (asign),
    .bsign (bsign),
    .m     (m),
    .sign  (sign),
    .rst_n (rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input int x, input int y,
                                        input bit xs, input bit ys);
    int p;
    bit s;
    p = x * y;
    s = (xs != ys) && (p != 0);
    return {s, p[15:0]};
  endfunction

  task automatic step(input logic [7:0] ta, input logic [7:0] tb,
                      input logic tas, input logic tbs,
                      input logic trst);
    @(negedge clk);
    a     = ta;
    b     = tb;
    asign = tas;
    bsign = tbs;
    rst_n = trst;
    if (!trst) begin
      foreach (q[k]) q[k] = '0;
      q.push_back('0);
    end else begin
      q.push_back(model(int'(ta), int'(tb), tas, tbs));
    end
  endtask

  initial begin : monitor
    logic [16:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() >= 2) begin
        e = q.pop_front();
        compared++;
        if (m !== e[15:0] || sign !== e[16]) begin
          mismatched++;
          $display("FAIL product @%0t: got m=%h sign=%b, want m=%h sign=%b",
                   $time, m, sign, e[15:0], e[16]);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    if (!done) begin
      $display("FAIL timeout: driver did not finish, compared=%0d",
               compared);
      $finish;
    end
  end

  initial begin : driver
    logic [7:0] ra;
    logic [7:0] rb;
    compared   = 0;
    mismatched = 0;
    done       = 1'b0;
    a = '0; b = '0; asign = 1'b0; bsign = 1'b0; rst_n = 1'b0;

    repeat (2) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    if (m !== 16'h0000 || sign !== 1'b0) begin
      mismatched++;
      $display("FAIL reset state @%0t: got m=%h sign=%b",
               $time, m, sign);
    end

    repeat (5) step(8'd3, 8'd1, 1'b1, 1'b1, 1'b1);
    repeat (3) step(8'd12, 8'd15, 1'b1, 1'b1, 1'b1);
    repeat (2) step(8'd255, 8'd255, 1'b1, 1'b0, 1'b1);
    repeat (2) step(8'd0, 8'd200, 1'b0, 1'b1, 1'b1);

    for (int i = 1; i <= 10; i++)
      step(8'(i), 8'd7, i[0], 1'b0, 1'b1);

    for (int i = 1; i <= 10; i++)
      step(8'(i), 8'd7, i[0], ~i[0], (i != 5));

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      case ($urandom_range(0, 9))
        0: ra = 8'd0;
        1: rb = 8'd255;
        2: ra = 8'd255;
        default: ;
      endcase
      step(ra, rb, 1'($urandom), 1'($urandom),
           ($urandom_range(0, 24) != 0));
    end

    repeat (3) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    done = 1'b1;
    if (mismatched != 0 || compared < 300)
      $display("FAIL summary: compared=%0d mismatched=%0d",
               compared, mismatched);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
